tri_raster: RTL and testbench
=============================

# tri_raster

Sequential triangle rasterizer: the producer-side counterpart to the point-in-triangle tester. It takes three vertices, scans the bounding box in row-major order and evaluates the same three edge functions on every candidate point. Each covered point is emitted on a valid/ready stream. It sits between the vertex source and any pixel consumer (framebuffer writer, coverage counter).

## Interface
- COORD_W, 12: unsigned coordinate width for vertices and pixels.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- ptAX, ptAY, ptBX, ptBY, ptCX, ptCY  in  COORD_W each  vertices A, B, C; sampled with start.
- busy  out  1  high in every state other than IDLE.
- pix_valid  out  1  pix_x/pix_y hold a covered point.
- pix_ready  in  1  consumer accepts the point when pix_valid & pix_ready.
- pix_x, pix_y  out  COORD_W each  covered point coordinates.
- done  out  1  one-cycle pulse at end of triangle.
- pix_count  out  2*COORD_W  pixels accepted for the current or last triangle.

## Operation
- The block has four states: IDLE, SETUP, SCAN and FLUSH.
- IDLE: on start, latch the vertices, clear pix_count and go to SETUP. start is ignored in every other state.
- SETUP (1 cycle):
  - xmin/xmax = min/max of the three X coordinates; ymin/ymax likewise.
  - Set the raster pointer to (xmin, ymin), then go to SCAN.
- Edge function for directed edge P->Q at candidate (x,y): E = (x-Qx)*(Py-Qy) - (Px-Qx)*(y-Qy).
  - Each operand is zero-extended to COORD_W+1 signed before subtraction.
  - Products are 2*COORD_W+2 signed; E is 2*COORD_W+3 signed (27 bits at default). No overflow is possible.
- The three edges are A->B, B->C and C->A.
- Coverage is inclusive: the point is inside when all three E >= 0. Points on an edge or vertex are covered.
- SCAN:
  - A candidate is evaluated in every cycle the output slot is free, i.e. !pix_valid or (pix_valid & pix_ready).
  - If the candidate is covered, load pix_x/pix_y and set pix_valid. If it is not covered and the slot is freed, clear pix_valid.
  - Advance x. At x == xmax, wrap to xmin and increment y.
  - When (xmax, ymax) has been evaluated, go to FLUSH.
- FLUSH: wait until pix_valid is low or the held point is accepted. Then pulse done for one cycle, go to IDLE and drop busy.
- pix_count increments on every pix_valid & pix_ready handshake.
- Degenerate triangles:
  - Collinear vertices emit the covered points on the line.
  - Three identical vertices emit exactly that point.

## Timing
- Reset values: state IDLE, busy 0, pix_valid 0, pix_x 0, pix_y 0, done 0, pix_count 0.
- Reset mid-operation aborts the triangle immediately. No done pulse is generated.
- Latency: start sampled at edge 0, SETUP at edge 1, first candidate registered at edge 2.
  - pix_valid can therefore first be high after edge 2.
- Throughput: one candidate per cycle while pix_ready = 1.
- Total triangle time is 2 + (bbox candidates) + 1 cycles at full throughput.
- Handshake rules:
  - pix_x/pix_y are stable while pix_valid & !pix_ready.
  - pix_valid never drops without a handshake.
  - pix_valid is independent of pix_ready (no combinational path).
- done and pix_valid are never high in the same cycle. pix_count is final when done is high.

## Configuration
- TRI_RASTER_BOTH_WIND_EN defined: a point is also covered when all three E <= 0. Clockwise and counter-clockwise triangles are then both rasterized.
- TRI_RASTER_BOTH_WIND_EN undefined: only all-E >= 0 counts. A clockwise triangle emits zero pixels (except degenerate points with all E = 0) and still completes with done.

## Structure
- Package tri_pkg holds the following:
  - COORD_W default.
  - The EDGE_W = 2*COORD_W+3 localparam.
  - The state enum {IDLE, SETUP, SCAN, FLUSH}.
- Sub-module tri_edge is purely combinational, computing E for one edge and a candidate point. It is instantiated three times.
- Bbox, pointer, output register and FSM live in tri_raster.

## Test plan
- Triangle A(0,0), B(2,0), C(0,2), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(0,1),(1,1),(0,2) in that order. done occurs 12 cycles after start; pix_count=6.
- Same triangle, pix_ready held low 5 cycles at first pix_valid -> (0,0) held stable for 5 cycles, then the identical 6-pixel sequence.
- Clockwise A(0,0), B(0,2), C(2,0):
  - Macro undefined -> no pixels, done, pix_count=0.
  - Macro defined -> the same 6 pixels.
- A=B=C=(5,5) -> single pixel (5,5), pix_count=1.
- Triangle A(10,10), B(30,10), C(20,30) with rst_n pulsed low mid-SCAN -> busy, pix_valid and done drop at once and pix_count=0. A following start rasterizes normally, and (15,15) and (10,10) are emitted while (9,15) is not.
- start asserted during SCAN -> ignored; the current triangle completes unchanged.

Source files
------------

// File: rtl/tri_raster_pkg.sv
// Shared types and widths for the triangle rasterizer.
// Optional feature macro: TRI_RASTER_BOTH_WIND_EN.
package tri_pkg;
  localparam int COORD_W = 12;
  localparam int EDGE_W = 2*COORD_W+3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    FLUSH
  } state_t;
endpackage

// File: rtl/tri_raster_if.sv
// Covered-pixel stream: valid/ready handshake with x/y payload.
interface tri_raster_if #(
  parameter int W = tri_pkg::COORD_W
);
  logic         pix_valid;
  logic         pix_ready;
  logic [W-1:0] pix_x;
  logic [W-1:0] pix_y;

  modport master (
    output pix_valid,
    output pix_x,
    output pix_y,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_x,
    input  pix_y,
    output pix_ready
  );
endinterface

// File: rtl/tri_raster_edge.sv
// Edge function for directed edge P->Q at candidate (x,y).
// E = (x-Qx)*(Py-Qy) - (Px-Qx)*(y-Qy), exact signed result.
module tri_edge #(
  parameter int W = tri_pkg::COORD_W
) (
  input  logic [W-1:0]          px,
  input  logic [W-1:0]          py,
  input  logic [W-1:0]          qx,
  input  logic [W-1:0]          qy,
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          y,
  output logic signed [2*W+2:0] e
);
  localparam int PW = 2*W+2;

  logic signed [PW-1:0] dx;
  logic signed [PW-1:0] dy;
  logic signed [PW-1:0] dpx;
  logic signed [PW-1:0] dpy;
  logic signed [PW-1:0] p0;
  logic signed [PW-1:0] p1;

  // zero-extend far enough that differences and products are exact
  always_comb begin
    dx  = $signed({{(W+2){1'b0}}, x})
        - $signed({{(W+2){1'b0}}, qx});
    dy  = $signed({{(W+2){1'b0}}, y})
        - $signed({{(W+2){1'b0}}, qy});
    dpx = $signed({{(W+2){1'b0}}, px})
        - $signed({{(W+2){1'b0}}, qx});
    dpy = $signed({{(W+2){1'b0}}, py})
        - $signed({{(W+2){1'b0}}, qy});
    p0  = dx * dpy;
    p1  = dpx * dy;
    e   = $signed({p0[PW-1], p0})
        - $signed({p1[PW-1], p1});
  end
endmodule

// File: rtl/tri_raster.sv
// Sequential triangle rasterizer: bbox scan, edge tests, pixel stream.
// Define TRI_RASTER_BOTH_WIND_EN to also cover clockwise triangles.
module tri_raster #(
  parameter int COORD_W = tri_pkg::COORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_W-1:0]     ptAX,
  input  logic [COORD_W-1:0]     ptAY,
  input  logic [COORD_W-1:0]     ptBX,
  input  logic [COORD_W-1:0]     ptBY,
  input  logic [COORD_W-1:0]     ptCX,
  input  logic [COORD_W-1:0]     ptCY,
  output logic                   busy,
  output logic                   done,
  output logic [2*COORD_W-1:0]   pix_count,
  tri_raster_if.master           pix
);
  import tri_pkg::*;

  localparam int EW = 2*COORD_W+3;
  localparam logic [COORD_W-1:0] C1 = 1;
  localparam logic [2*COORD_W-1:0] N1 = 1;

  state_t state;

  logic [COORD_W-1:0] ax, ay, bx, by, cx, cy;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] rx, ry;

  logic signed [EW-1:0] e_ab, e_bc, e_ca;
  logic covered;
  logic free;
  logic last;

  function automatic logic [COORD_W-1:0] min3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  tri_edge #(.W(COORD_W)) u_ab (
    .px(ax), .py(ay), .qx(bx), .qy(by),
    .x(rx), .y(ry), .e(e_ab)
  );

  tri_edge #(.W(COORD_W)) u_bc (
    .px(bx), .py(by), .qx(cx), .qy(cy),
    .x(rx), .y(ry), .e(e_bc)
  );

  tri_edge #(.W(COORD_W)) u_ca (
    .px(cx), .py(cy), .qx(ax), .qy(ay),
    .x(rx), .y(ry), .e(e_ca)
  );

  always_comb begin
    covered = !e_ab[EW-1] && !e_bc[EW-1]
           && !e_ca[EW-1];
`ifdef TRI_RASTER_BOTH_WIND_EN
    covered = covered
      || ((e_ab[EW-1] || e_ab == '0)
       && (e_bc[EW-1] || e_bc == '0)
       && (e_ca[EW-1] || e_ca == '0));
`endif
    free = !pix.pix_valid || pix.pix_ready;
    last = (rx == xmax) && (ry == ymax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pix_count     <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_x     <= '0;
      pix.pix_y     <= '0;
      ax <= '0; ay <= '0;
      bx <= '0; by <= '0;
      cx <= '0; cy <= '0;
      xmin <= '0; xmax <= '0;
      ymin <= '0; ymax <= '0;
      rx <= '0; ry <= '0;
    end else begin
      done <= 1'b0;
      if (pix.pix_valid && pix.pix_ready)
        pix_count <= pix_count + N1;
      unique case (state)
        IDLE: begin
          if (start) begin
            ax <= ptAX; ay <= ptAY;
            bx <= ptBX; by <= ptBY;
            cx <= ptCX; cy <= ptCY;
            pix_count <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          xmin  <= min3(ax, bx, cx);
          xmax  <= max3(ax, bx, cx);
          ymin  <= min3(ay, by, cy);
          ymax  <= max3(ay, by, cy);
          rx    <= min3(ax, bx, cx);
          ry    <= min3(ay, by, cy);
          state <= SCAN;
        end
        SCAN: begin
          if (free) begin
            if (covered) begin
              pix.pix_valid <= 1'b1;
              pix.pix_x     <= rx;
              pix.pix_y     <= ry;
            end else begin
              pix.pix_valid <= 1'b0;
            end
            if (last) begin
              state <= FLUSH;
            end else if (rx == xmax) begin
              rx <= xmin;
              ry <= ry + C1;
            end else begin
              rx <= rx + C1;
            end
          end
        end
        FLUSH: begin
          // last held point must drain before done
          if (free) begin
            pix.pix_valid <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_raster.sv
// Directed testbench for tri_raster.
// Honours TRI_RASTER_BOTH_WIND_EN for the clockwise case.
module tb_tri_raster;
  import tri_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] ptAX = '0, ptAY = '0;
  logic [11:0] ptBX = '0, ptBY = '0;
  logic [11:0] ptCX = '0, ptCY = '0;
  logic        busy, done;
  logic [23:0] pix_count;

  tri_raster_if #(.W(COORD_W)) pix ();

  always #5 clk = ~clk;

  tri_raster dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ptAX(ptAX), .ptAY(ptAY),
    .ptBX(ptBX), .ptBY(ptBY),
    .ptCX(ptCX), .ptCY(ptCY),
    .busy(busy), .done(done),
    .pix_count(pix_count), .pix(pix)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] qx[$];
  logic [11:0] qy[$];
  int          done_cyc;
  int          hold_bad;
  logic        overlap;
  logic [23:0] pc_done;

  int ex[6] = '{0, 1, 2, 0, 1, 0};
  int ey[6] = '{0, 0, 0, 1, 1, 2};

  task automatic run_tri(
    input int vax, input int vay,
    input int vbx, input int vby,
    input int vcx, input int vcy,
    input int stall, input int inj,
    input int budget
  );
    int cyc;
    int hold_left;
    logic stalled;
    logic [11:0] hx, hy;
    qx.delete();
    qy.delete();
    done_cyc = -1;
    hold_bad = 0;
    overlap = 1'b0;
    pc_done = '0;
    stalled = 1'b0;
    hold_left = 0;
    hx = '0;
    hy = '0;
    @(negedge clk);
    ptAX = vax[11:0]; ptAY = vay[11:0];
    ptBX = vbx[11:0]; ptBY = vby[11:0];
    ptCX = vcx[11:0]; ptCY = vcy[11:0];
    start = 1'b1;
    pix.pix_ready = 1'b1;
    cyc = 0;
    while (cyc < budget && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inj) begin
        start = 1'b1;
        ptAX = 12'd5; ptAY = 12'd5;
        ptBX = 12'd5; ptBY = 12'd5;
        ptCX = 12'd5; ptCY = 12'd5;
      end
      if (done) begin
        done_cyc = cyc;
        pc_done = pix_count;
        if (pix.pix_valid) overlap = 1'b1;
      end
      if (stall > 0 && !stalled && pix.pix_valid) begin
        stalled = 1'b1;
        pix.pix_ready = 1'b0;
        hx = pix.pix_x;
        hy = pix.pix_y;
        hold_left = stall;
      end else if (hold_left > 0) begin
        if (!(pix.pix_valid && pix.pix_x == hx
              && pix.pix_y == hy))
          hold_bad++;
        hold_left--;
        if (hold_left == 0) pix.pix_ready = 1'b1;
      end
      if (pix.pix_valid && pix.pix_ready) begin
        qx.push_back(pix.pix_x);
        qy.push_back(pix.pix_y);
      end
    end
    pix.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    pix.pix_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (pix.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0",
               pix.pix_valid);
    end
    checks++;
    if (pix.pix_x !== 12'd0 || pix.pix_y !== 12'd0) begin
      errors++;
      $display("FAIL reset_xy: got %0d,%0d want 0,0",
               pix.pix_x, pix.pix_y);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (pix_count !== 24'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0",
               pix_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_tri(0, 0, 2, 0, 0, 2, 0, 0, 100);
    checks++;
    if (done_cyc != 12) begin
      errors++;
      $display("FAIL basic_done_cyc: got %0d want 12",
               done_cyc);
    end
    checks++;
    if (qx.size() != 6) begin
      errors++;
      $display("FAIL basic_npix: got %0d want 6",
               qx.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= qx.size() || qx[i] !== 12'(ex[i])
          || qy[i] !== 12'(ey[i])) begin
        errors++;
        $display("FAIL basic_pix%0d: got %0d,%0d want %0d,%0d",
                 i, (i < qx.size()) ? qx[i] : 12'hfff,
                 (i < qy.size()) ? qy[i] : 12'hfff,
                 ex[i], ey[i]);
      end
    end
    checks++;
    if (pc_done !== 24'd6) begin
      errors++;
      $display("FAIL basic_count: got %0d want 6", pc_done);
    end
    checks++;
    if (overlap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: overlap %b busy %b want 0 0",
               overlap, busy);
    end
  endtask

  task automatic test_backpressure();
    run_tri(0, 0, 2, 0, 0, 2, 5, 0, 100);
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable want 0",
               hold_bad);
    end
    checks++;
    if (done_cyc != 17) begin
      errors++;
      $display("FAIL bp_done_cyc: got %0d want 17", done_cyc);
    end
    checks++;
    if (qx.size() != 6) begin
      errors++;
      $display("FAIL bp_npix: got %0d want 6", qx.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= qx.size() || qx[i] !== 12'(ex[i])
          || qy[i] !== 12'(ey[i])) begin
        errors++;
        $display("FAIL bp_pix%0d: want %0d,%0d",
                 i, ex[i], ey[i]);
      end
    end
    checks++;
    if (pc_done !== 24'd6) begin
      errors++;
      $display("FAIL bp_count: got %0d want 6", pc_done);
    end
  endtask

  task automatic test_clockwise();
    int exp_n;
`ifdef TRI_RASTER_BOTH_WIND_EN
    exp_n = 6;
`else
    exp_n = 0;
`endif
    run_tri(0, 0, 0, 2, 2, 0, 0, 0, 100);
    checks++;
    if (done_cyc != 12) begin
      errors++;
      $display("FAIL cw_done_cyc: got %0d want 12", done_cyc);
    end
    checks++;
    if (qx.size() != exp_n || pc_done !== 24'(exp_n)) begin
      errors++;
      $display("FAIL cw_npix: got %0d/%0d want %0d",
               qx.size(), pc_done, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (i >= qx.size() || qx[i] !== 12'(ex[i])
          || qy[i] !== 12'(ey[i])) begin
        errors++;
        $display("FAIL cw_pix%0d: want %0d,%0d",
                 i, ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_point();
    run_tri(5, 5, 5, 5, 5, 5, 0, 0, 50);
    checks++;
    if (done_cyc != 4) begin
      errors++;
      $display("FAIL pt_done_cyc: got %0d want 4", done_cyc);
    end
    checks++;
    if (qx.size() != 1 || pc_done !== 24'd1) begin
      errors++;
      $display("FAIL pt_npix: got %0d/%0d want 1",
               qx.size(), pc_done);
    end else if (qx[0] !== 12'd5 || qy[0] !== 12'd5) begin
      errors++;
      $display("FAIL pt_xy: got %0d,%0d want 5,5",
               qx[0], qy[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic f1515, f1010, f915;
    @(negedge clk);
    ptAX = 12'd10; ptAY = 12'd10;
    ptBX = 12'd30; ptBY = 12'd10;
    ptCX = 12'd20; ptCY = 12'd30;
    start = 1'b1;
    pix.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || pix.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: busy %b valid %b want 1 1",
               busy, pix.pix_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || pix.pix_valid !== 1'b0
        || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: busy %b valid %b done %b want 0",
               busy, pix.pix_valid, done);
    end
    checks++;
    if (pix_count !== 24'd0) begin
      errors++;
      $display("FAIL mid_count: got %0d want 0", pix_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_tri(10, 10, 30, 10, 20, 30, 0, 0, 800);
    checks++;
    if (done_cyc != 444) begin
      errors++;
      $display("FAIL mid_done_cyc: got %0d want 444",
               done_cyc);
    end
    f1515 = 1'b0; f1010 = 1'b0; f915 = 1'b0;
    for (int i = 0; i < qx.size(); i++) begin
      if (qx[i] == 12'd15 && qy[i] == 12'd15) f1515 = 1'b1;
      if (qx[i] == 12'd10 && qy[i] == 12'd10) f1010 = 1'b1;
      if (qx[i] == 12'd9 && qy[i] == 12'd15) f915 = 1'b1;
    end
    checks++;
    if (f1515 !== 1'b1 || f1010 !== 1'b1) begin
      errors++;
      $display("FAIL mid_inside: (15,15)=%b (10,10)=%b want 1 1",
               f1515, f1010);
    end
    checks++;
    if (f915 !== 1'b0) begin
      errors++;
      $display("FAIL mid_outside: (9,15)=%b want 0", f915);
    end
    checks++;
    if (qx.size() == 0 || qx[0] !== 12'd10
        || qy[0] !== 12'd10) begin
      errors++;
      $display("FAIL mid_first: npix %0d want first 10,10",
               qx.size());
    end
    checks++;
    if (pc_done !== 24'(qx.size())) begin
      errors++;
      $display("FAIL mid_count2: got %0d want %0d",
               pc_done, qx.size());
    end
  endtask

  task automatic test_start_ignored();
    run_tri(0, 0, 2, 0, 0, 2, 0, 5, 100);
    checks++;
    if (done_cyc != 12) begin
      errors++;
      $display("FAIL ign_done_cyc: got %0d want 12", done_cyc);
    end
    checks++;
    if (qx.size() != 6 || pc_done !== 24'd6) begin
      errors++;
      $display("FAIL ign_npix: got %0d/%0d want 6",
               qx.size(), pc_done);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= qx.size() || qx[i] !== 12'(ex[i])
          || qy[i] !== 12'(ey[i])) begin
        errors++;
        $display("FAIL ign_pix%0d: want %0d,%0d",
                 i, ex[i], ey[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: busy %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clockwise();
    test_point();
    test_reset_mid();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
